regfile_writeback: RTL and testbench



---
 rtl/regfile_writeback.sv | 104 ++++++++++
 tb/tb_regfile_writeback.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// Writeback stage with a one-entry pending register, a 32x32 writable register
// file, and two registered operand read ports bypassed from the pending entry.
module regfile_writeback #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned ERRW  = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [4:0]      ReadReg1,
  input  logic [4:0]      ReadReg2,
  input  logic            RdEn,
  input  logic            WbValid,
  input  logic [4:0]      WriteReg,
  input  logic [31:0]     WbData,
  input  logic [3:0]      WbCtl,
  output logic [31:0]     A,
  output logic [31:0]     B,
  output logic            WbPending,
  output logic [ERRW-1:0] ErrCount
);

  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;
  localparam int unsigned CTLW = 4;

  localparam logic [CTLW-1:0] CTL_ILLEGAL = CTLW'(15);
  localparam logic [ERRW-1:0] ERR_MAX     = '1;

  logic [DW-1:0]   regs [NREGS];
  logic            wb_v;
  logic [AW-1:0]   wb_reg;
  logic [DW-1:0]   wb_data;

  logic            legal_c;
  logic            illegal_c;
  logic [DW-1:0]   a_next_c;
  logic [DW-1:0]   b_next_c;
  logic [ERRW-1:0] err_next_c;

  // Register file contents after reset: r0..r3 preloaded, the rest cleared.
  function automatic logic [DW-1:0] reset_value(input int unsigned idx);
    case (idx)
      0:       reset_value = DW'(3);
      1:       reset_value = DW'(4);
      2:       reset_value = DW'(1);
      3:       reset_value = DW'(2);
      default: reset_value = '0;
    endcase
  endfunction

  // Result classification, bypassed operand selection and saturating error count.
  always_comb begin
    legal_c    = WbValid && (WbCtl != CTL_ILLEGAL);
    illegal_c  = WbValid && (WbCtl == CTL_ILLEGAL);

    a_next_c   = regs[ReadReg1];
    if (wb_v && (wb_reg == ReadReg1)) begin
      a_next_c = wb_data;
    end

    b_next_c   = regs[ReadReg2];
    if (wb_v && (wb_reg == ReadReg2)) begin
      b_next_c = wb_data;
    end

    err_next_c = ErrCount;
    if (illegal_c && (ErrCount != ERR_MAX)) begin
      err_next_c = ErrCount + ERRW'(1);
    end
  end

  // Commit the pending entry while capturing the next one, so results stream
  // one per cycle; reset drops the pending entry without committing it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs[AW'(i)] <= reset_value(i);
      end
      wb_v     <= 1'b0;
      wb_reg   <= '0;
      wb_data  <= '0;
      A        <= '0;
      B        <= '0;
      ErrCount <= '0;
    end else begin
      if (wb_v) begin
        regs[wb_reg] <= wb_data;
      end
      wb_v <= legal_c;
      if (legal_c) begin
        wb_reg  <= WriteReg;
        wb_data <= WbData;
      end
      if (RdEn) begin
        A <= a_next_c;
        B <= b_next_c;
      end
      ErrCount <= err_next_c;
    end
  end

  assign WbPending = wb_v;

endmodule

// File: tb/tb_regfile_writeback.sv
// Scenario bench for regfile_writeback: expected operands are queued when a
// read is strobed and compared once the strobing edge has passed.
module tb_regfile_writeback;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic        RdEn;
  logic        WbValid;
  logic [4:0]  WriteReg;
  logic [31:0] WbData;
  logic [3:0]  WbCtl;
  logic [31:0] A;
  logic [31:0] B;
  logic        WbPending;
  logic [7:0]  ErrCount;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  regfile_writeback #(.NREGS(32), .ERRW(8)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .RdEn      (RdEn),
    .WbValid   (WbValid),
    .WriteReg  (WriteReg),
    .WbData    (WbData),
    .WbCtl     (WbCtl),
    .A         (A),
    .B         (B),
    .WbPending (WbPending),
    .ErrCount  (ErrCount)
  );

  always #5 CLK = ~CLK;

  task automatic set_in(input logic v, input logic [4:0] wr, input logic [31:0] d,
                        input logic [3:0] ctl, input logic rd,
                        input logic [4:0] r1, input logic [4:0] r2);
    WbValid  = v;
    WriteReg = wr;
    WbData   = d;
    WbCtl    = ctl;
    RdEn     = rd;
    ReadReg1 = r1;
    ReadReg2 = r2;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.a = a;
    e.b = b;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    exp_t e;
    RESET = 1'b1;
    set_in(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 5'd0);
    step();
    RESET = 1'b0;
    vectors++;
    if (A !== 32'd0 || B !== 32'd0) begin
      $display("FAIL reset_ab: A=%0h B=%0h expected 0/0", A, B); miscompares++;
    end
    vectors++;
    if (ErrCount !== 8'd0 || WbPending !== 1'b0) begin
      $display("FAIL reset_status: ErrCount=%0d WbPending=%b expected 0/0", ErrCount, WbPending);
      miscompares++;
    end
    set_in(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd0, 5'd1);
    push_exp(32'd3, 32'd4);
    step();
    e = sb.pop_front();
    vectors++;
    if (A !== e.a || B !== e.b) begin
      $display("FAIL reset_regs: A=%0h B=%0h expected %0h/%0h", A, B, e.a, e.b); miscompares++;
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    // Edge ending N: incoming result is not bypassed yet.
    set_in(1'b1, 5'd2, 32'd7, 4'd2, 1'b1, 5'd2, 5'd2);
    push_exp(32'd1, 32'd1);
    step();
    e = sb.pop_front();
    vectors++;
    if (A !== e.a || B !== e.b) begin
      $display("FAIL wr_old: A=%0h B=%0h expected %0h/%0h", A, B, e.a, e.b); miscompares++;
    end
    vectors++;
    if (WbPending !== 1'b1) begin
      $display("FAIL wr_pending: WbPending=%b expected 1", WbPending); miscompares++;
    end
    set_in(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd2, 5'd3);
    push_exp(32'd7, 32'd2);
    step();
    e = sb.pop_front();
    vectors++;
    if (A !== e.a || B !== e.b) begin
      $display("FAIL wr_bypass: A=%0h B=%0h expected %0h/%0h", A, B, e.a, e.b); miscompares++;
    end
    vectors++;
    if (WbPending !== 1'b0) begin
      $display("FAIL wr_pending_fall: WbPending=%b expected 0", WbPending); miscompares++;
    end
    set_in(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd2, 5'd2);
    push_exp(32'd7, 32'd7);
    step();
    e = sb.pop_front();
    vectors++;
    if (A !== e.a || B !== e.b) begin
      $display("FAIL wr_committed: A=%0h B=%0h expected %0h/%0h", A, B, e.a, e.b); miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    set_in(1'b1, 5'd5, 32'hA, 4'd0, 1'b0, 5'd0, 5'd0);
    step();
    vectors++;
    if (WbPending !== 1'b1) begin
      $display("FAIL b2b_pend1: WbPending=%b expected 1", WbPending); miscompares++;
    end
    set_in(1'b1, 5'd5, 32'hB, 4'd0, 1'b1, 5'd5, 5'd5);
    push_exp(32'hA, 32'hA);
    step();
    e = sb.pop_front();
    vectors++;
    if (A !== e.a || B !== e.b) begin
      $display("FAIL b2b_bypass: A=%0h B=%0h expected %0h/%0h", A, B, e.a, e.b); miscompares++;
    end
    vectors++;
    if (WbPending !== 1'b1) begin
      $display("FAIL b2b_pend2: WbPending=%b expected 1", WbPending); miscompares++;
    end
    set_in(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 5'd0);
    step();
    vectors++;
    if (WbPending !== 1'b0) begin
      $display("FAIL b2b_pend3: WbPending=%b expected 0", WbPending); miscompares++;
    end
    set_in(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd5, 5'd2);
    push_exp(32'hB, 32'd7);
    step();
    e = sb.pop_front();
    vectors++;
    if (A !== e.a || B !== e.b) begin
      $display("FAIL b2b_final: A=%0h B=%0h expected %0h/%0h", A, B, e.a, e.b); miscompares++;
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    set_in(1'b1, 5'd3, 32'hFF, 4'd15, 1'b0, 5'd0, 5'd0);
    step();
    vectors++;
    if (ErrCount !== 8'd1 || WbPending !== 1'b0) begin
      $display("FAIL ill_first: ErrCount=%0d WbPending=%b expected 1/0", ErrCount, WbPending);
      miscompares++;
    end
    set_in(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd3, 5'd3);
    push_exp(32'd2, 32'd2);
    step();
    e = sb.pop_front();
    vectors++;
    if (A !== e.a || B !== e.b) begin
      $display("FAIL ill_noreg: A=%0h B=%0h expected %0h/%0h", A, B, e.a, e.b); miscompares++;
    end
    for (int i = 0; i < 299; i++) begin
      set_in(1'b1, 5'd3, 32'hFF, 4'd15, 1'b0, 5'd0, 5'd0);
      step();
    end
    vectors++;
    if (ErrCount !== 8'd255) begin
      $display("FAIL ill_saturate: ErrCount=%0d expected 255", ErrCount); miscompares++;
    end
    set_in(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd3, 5'd1);
    push_exp(32'd2, 32'd4);
    step();
    e = sb.pop_front();
    vectors++;
    if (A !== e.a || B !== e.b) begin
      $display("FAIL ill_regs_after: A=%0h B=%0h expected %0h/%0h", A, B, e.a, e.b); miscompares++;
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    set_in(1'b1, 5'd0, 32'h55, 4'd1, 1'b0, 5'd0, 5'd0);
    step();
    vectors++;
    if (WbPending !== 1'b1) begin
      $display("FAIL rstmid_pend: WbPending=%b expected 1", WbPending); miscompares++;
    end
    // Reset wins over a simultaneous legal result and read strobe.
    RESET = 1'b1;
    set_in(1'b1, 5'd1, 32'h77, 4'd0, 1'b1, 5'd0, 5'd0);
    step();
    RESET = 1'b0;
    vectors++;
    if (A !== 32'd0 || B !== 32'd0 || WbPending !== 1'b0 || ErrCount !== 8'd0) begin
      $display("FAIL rstmid_state: A=%0h B=%0h WbPending=%b ErrCount=%0d expected 0/0/0/0",
               A, B, WbPending, ErrCount);
      miscompares++;
    end
    set_in(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd0, 5'd1);
    push_exp(32'd3, 32'd4);
    step();
    e = sb.pop_front();
    vectors++;
    if (A !== e.a || B !== e.b) begin
      $display("FAIL rstmid_dropped: A=%0h B=%0h expected %0h/%0h", A, B, e.a, e.b); miscompares++;
    end
  endtask

  task automatic test_dual_bypass();
    exp_t e;
    set_in(1'b1, 5'd4, 32'd9, 4'd3, 1'b0, 5'd0, 5'd0);
    step();
    set_in(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd4, 5'd4);
    push_exp(32'd9, 32'd9);
    step();
    e = sb.pop_front();
    vectors++;
    if (A !== e.a || B !== e.b) begin
      $display("FAIL dual_bypass: A=%0h B=%0h expected %0h/%0h", A, B, e.a, e.b); miscompares++;
    end
    set_in(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd1, 5'd2);
    step();
    vectors++;
    if (A !== 32'd9 || B !== 32'd9) begin
      $display("FAIL dual_hold: A=%0h B=%0h expected 9/9", A, B); miscompares++;
    end
    set_in(1'b0, 5'd0, 32'd0, 4'd0, 1'b1, 5'd4, 5'd3);
    push_exp(32'd9, 32'd2);
    step();
    e = sb.pop_front();
    vectors++;
    if (A !== e.a || B !== e.b) begin
      $display("FAIL dual_commit: A=%0h B=%0h expected %0h/%0h", A, B, e.a, e.b); miscompares++;
    end
  endtask

  initial begin
    RESET = 1'b0;
    set_in(1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 5'd0, 5'd0);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_dual_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
